// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//    Shares the single register-file write port between the in-order pipeline
//    write-back stage and a long-latency result source (multi-cycle mul/div).
//    Long-latency results wait in a small FIFO. The pipeline normally wins the
//    port. A starvation counter forces a one-cycle pipeline stall so the FIFO
//    can drain. Buffered results whose rd is overwritten by a younger pipeline
//    write are squashed, so write-after-write order is preserved.
//
// Parameters:
//    DEPTH        - long-latency FIFO entries (power of 2, >= 2)
//    STARVE_LIMIT - consecutive cycles the pipeline may block a non-empty FIFO
//                   before a forced drain
//
// Ports:
//    clk, rst_n               - clock, asynchronous active-low reset
//    wb_valid/wb_rd/wb_data   - pipeline write-back request
//    wb_stall                 - pipeline must hold WB this cycle (combinational)
//    ll_valid/ll_rd/ll_data   - long-latency result offer
//    ll_ready                 - FIFO can accept (combinational)
//    rf_we/rf_waddr/rf_wdata  - register-file write port (registered)
//    fifo_cnt                 - FIFO occupancy (registered)
//    stall_cycles             - count of stalled cycles, saturating
//                               (only when WB_ARB_PERF_EN is defined)
//
// Build option:
//    WB_ARB_PERF_EN - adds the stall_cycles performance counter output.
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_rd,
   input  logic [31:0]              wb_data,
   output logic                     wb_stall,
   input  logic                     ll_valid,
   input  logic [4:0]               ll_rd,
   input  logic [31:0]              ll_data,
   output logic                     ll_ready,
   output logic                     rf_we,
   output logic [4:0]               rf_waddr,
   output logic [31:0]              rf_wdata,
   output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0]              stall_cycles
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LAST  = SW'(STARVE_LIMIT - 1);

   // Arbiter FSM states
   localparam logic ARB_PIPE  = 1'b0;
   localparam logic ARB_FORCE = 1'b1;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic             r_state;
   logic [SW-1:0]    r_starve;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_cnt;
   logic [DEPTH-1:0] r_vld;
   logic [4:0]       r_rd_mem   [DEPTH];
   logic [31:0]      r_data_mem [DEPTH];

   logic             r_rf_we;
   logic [4:0]       r_rf_waddr;
   logic [31:0]      r_rf_wdata;

   // ---------------------------------------------------------------------------
   // Combinational decode
   // ---------------------------------------------------------------------------
   logic             w_empty;
   logic             w_push;
   logic             w_pipe_cand;
   logic             w_pop;
   logic             w_starve_inc;
   logic [4:0]       w_head_rd;
   logic [31:0]      w_head_data;
   logic             w_head_we;
   logic [DEPTH-1:0] w_match;
   logic [DEPTH-1:0] w_vld_next;
   logic             w_state_next;
   logic [SW-1:0]    w_starve_next;
   logic             w_rf_we_next;
   logic [4:0]       w_rf_waddr_next;
   logic [31:0]      w_rf_wdata_next;

   assign w_empty  = (r_cnt == '0);
   // Acceptance ignores a same-cycle pop so ll_ready never depends on wb_valid.
   assign ll_ready = (r_cnt < DEPTH_C);
   assign w_push   = ll_valid && ll_ready;
   assign wb_stall = (r_state == ARB_FORCE);

   // x0 writes never claim the port, so they do not block the FIFO either.
   assign w_pipe_cand = wb_valid && !wb_stall && (wb_rd != 5'd0);

   // In ARB_FORCE the pipeline is stalled, so the candidate is already false
   // and the head pops through the same expression.
   assign w_pop        = !w_empty && !w_pipe_cand;
   assign w_starve_inc = !w_empty && w_pipe_cand;

   assign w_head_rd   = r_rd_mem[r_rptr];
   assign w_head_data = r_data_mem[r_rptr];
   assign w_head_we   = r_vld[r_rptr] && (w_head_rd != 5'd0);

   // Per-slot rd match against the pipeline destination. Gated with the valid
   // bit so empty slots (never written since reset) cannot produce a match.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign w_match[gi] = r_vld[gi] && (r_rd_mem[gi] == wb_rd);
      end
   endgenerate

   // Valid-bit update. The push is applied last: a result entering the FIFO
   // in the same cycle as a matching pipeline write is the younger one and
   // must survive the squash.
   always_comb begin
      w_vld_next = r_vld;
      if (w_pipe_cand) begin
         w_vld_next = w_vld_next & ~w_match;
      end
      if (w_pop) begin
         w_vld_next[r_rptr] = 1'b0;
      end
      if (w_push) begin
         w_vld_next[r_wptr] = 1'b1;
      end
   end

   // Write-port selection. A squashed pop still consumes the slot and leaves
   // the port idle for that cycle.
   always_comb begin
      w_rf_we_next    = 1'b0;
      w_rf_waddr_next = r_rf_waddr;
      w_rf_wdata_next = r_rf_wdata;
      if (w_pipe_cand) begin
         w_rf_we_next    = 1'b1;
         w_rf_waddr_next = wb_rd;
         w_rf_wdata_next = wb_data;
      end else if (w_pop && w_head_we) begin
         w_rf_we_next    = 1'b1;
         w_rf_waddr_next = w_head_rd;
         w_rf_wdata_next = w_head_data;
      end
   end

   // Starvation tracking. The counter only survives cycles where the FIFO is
   // occupied and the pipeline took the port; any pop or empty cycle clears it.
   always_comb begin
      w_state_next  = r_state;
      w_starve_next = r_starve;
      case (r_state)
         ARB_PIPE: begin
            if (w_starve_inc) begin
               if (r_starve == STARVE_LAST) begin
                  w_state_next  = ARB_FORCE;
                  w_starve_next = '0;
               end else begin
                  w_starve_next = r_starve + SW'(1);
               end
            end else begin
               w_starve_next = '0;
            end
         end
         ARB_FORCE: begin
            w_state_next  = ARB_PIPE;
            w_starve_next = '0;
         end
         default: begin
            w_state_next  = ARB_PIPE;
            w_starve_next = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ARB_PIPE;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_next;
         r_starve <= w_starve_next;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_vld  <= '0;
      end else begin
         r_vld <= w_vld_next;
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Payload storage carries no reset; occupancy is tracked by r_vld/r_cnt.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd_mem[r_wptr]   <= ll_rd;
         r_data_mem[r_wptr] <= ll_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= 5'd0;
         r_rf_wdata <= 32'd0;
      end else begin
         r_rf_we    <= w_rf_we_next;
         r_rf_waddr <= w_rf_waddr_next;
         r_rf_wdata <= w_rf_wdata_next;
      end
   end

   assign rf_we    = r_rf_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;
   assign fifo_cnt = r_cnt;

`ifdef WB_ARB_PERF_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= 32'd0;
      end else if (wb_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Self-checking bench for wb_port_arbiter. Directed scenarios follow the
// block's intended use cases; a randomized phase compares every cycle with a
// queue-based reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 4;
   localparam int CW           = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wb_valid;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;
   logic          wb_stall;
   logic          ll_valid;
   logic [4:0]    ll_rd;
   logic [31:0]   ll_data;
   logic          ll_ready;
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic [CW-1:0] fifo_cnt;
`ifdef WB_ARB_PERF_EN
   logic [31:0]   stall_cycles;
`endif

   int checks = 0;
   int passes = 0;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .wb_stall (wb_stall),
      .ll_valid (ll_valid),
      .ll_rd    (ll_rd),
      .ll_data  (ll_data),
      .ll_ready (ll_ready),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .fifo_cnt (fifo_cnt)
`ifdef WB_ARB_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Reference model state: buffered results in arrival order.
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        v;
   } ent_t;

   ent_t    m_q[$];
   bit      m_force;
   int      m_starve;
   longint  m_stalls;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      wb_valid = v;
      wb_rd    = rd;
      wb_data  = d;
      ll_valid = lv;
      ll_rd    = lrd;
      ll_data  = ld;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #2;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, fifo_cnt} !== '0) begin
         $display("FAIL reset_hold: got we=%b addr=%0d data=%h cnt=%0d, want all zero",
                  rf_we, rf_waddr, rf_wdata, fifo_cnt);
      end else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({rf_we, fifo_cnt, ll_ready, wb_stall} !== {1'b0, CW'(0), 1'b1, 1'b0}) begin
            $display("FAIL reset_idle cyc%0d: got we=%b cnt=%0d ready=%b stall=%b, want 0/0/1/0",
                     i, rf_we, fifo_cnt, ll_ready, wb_stall);
         end else passes++;
         tick();
      end
      $display("test_reset done");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_pipe_write();
      drive(1, 5, 32'h1234, 0, 0, 0);
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
         $display("FAIL pipe_write: got we=%b addr=%0d data=%h, want 1/5/00001234",
                  rf_we, rf_waddr, rf_wdata);
      end else passes++;
      drive(1, 0, 32'h5678, 0, 0, 0);
      tick();
      checks++;
      if (rf_we !== 1'b0) begin
         $display("FAIL pipe_write_x0: got we=%b, want 0", rf_we);
      end else passes++;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      $display("test_pipe_write done");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_ll_drain();
      drive(0, 0, 0, 1, 7, 32'hAAAA);
      tick();
      checks++;
      if ({rf_we, fifo_cnt} !== {1'b0, CW'(1)}) begin
         $display("FAIL ll_push: got we=%b cnt=%0d, want 0/1", rf_we, fifo_cnt);
      end else passes++;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, fifo_cnt} !== {1'b1, 5'd7, 32'hAAAA, CW'(0)}) begin
         $display("FAIL ll_drain: got we=%b addr=%0d data=%h cnt=%0d, want 1/7/0000aaaa/0",
                  rf_we, rf_waddr, rf_wdata, fifo_cnt);
      end else passes++;
      tick();
      $display("test_ll_drain done");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_starvation();
      logic [31:0] d;
      drive(1, 3, 32'h3000_0000, 1, 8, 32'h8888);
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, fifo_cnt} !== {1'b1, 5'd3, 32'h3000_0000, CW'(1)}) begin
         $display("FAIL starve_push0: got we=%b addr=%0d data=%h cnt=%0d, want 1/3/30000000/1",
                  rf_we, rf_waddr, rf_wdata, fifo_cnt);
      end else passes++;
      drive(1, 3, 32'h3000_0001, 1, 9, 32'h9999);
      #1;
      checks++;
      if (ll_ready !== 1'b1) begin
         $display("FAIL starve_ready1: got ready=%b, want 1", ll_ready);
      end else passes++;
      tick();
      checks++;
      if (fifo_cnt !== CW'(2)) begin
         $display("FAIL starve_full: got cnt=%0d, want 2", fifo_cnt);
      end else passes++;
      // Three more pipeline writes with a full FIFO: no stall yet.
      for (int i = 0; i < 3; i++) begin
         d = 32'h3000_0010 + i;
         drive(1, 3, d, 0, 0, 0);
         #1;
         checks++;
         if ({ll_ready, wb_stall} !== 2'b00) begin
            $display("FAIL starve_block%0d: got ready=%b stall=%b, want 0/0", i, ll_ready, wb_stall);
         end else passes++;
         tick();
         checks++;
         if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, d}) begin
            $display("FAIL starve_pipe%0d: got we=%b addr=%0d data=%h, want 1/3/%h",
                     i, rf_we, rf_waddr, rf_wdata, d);
         end else passes++;
      end
      drive(1, 3, 32'h3000_0020, 0, 0, 0);
      #1;
      checks++;
      if (wb_stall !== 1'b1) begin
         $display("FAIL starve_force1: got stall=%b, want 1", wb_stall);
      end else passes++;
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, fifo_cnt} !== {1'b1, 5'd8, 32'h8888, CW'(1)}) begin
         $display("FAIL starve_drain8: got we=%b addr=%0d data=%h cnt=%0d, want 1/8/00008888/1",
                  rf_we, rf_waddr, rf_wdata, fifo_cnt);
      end else passes++;
      for (int i = 0; i < 4; i++) begin
         d = 32'h3100_0000 + i;
         drive(1, 3, d, 0, 0, 0);
         #1;
         checks++;
         if (wb_stall !== 1'b0) begin
            $display("FAIL starve_nostall%0d: got stall=%b, want 0", i, wb_stall);
         end else passes++;
         tick();
         checks++;
         if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, d}) begin
            $display("FAIL starve_pipe2_%0d: got we=%b addr=%0d data=%h, want 1/3/%h",
                     i, rf_we, rf_waddr, rf_wdata, d);
         end else passes++;
      end
      drive(1, 3, 32'h3200_0000, 0, 0, 0);
      #1;
      checks++;
      if (wb_stall !== 1'b1) begin
         $display("FAIL starve_force2: got stall=%b, want 1", wb_stall);
      end else passes++;
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, fifo_cnt} !== {1'b1, 5'd9, 32'h9999, CW'(0)}) begin
         $display("FAIL starve_drain9: got we=%b addr=%0d data=%h cnt=%0d, want 1/9/00009999/0",
                  rf_we, rf_waddr, rf_wdata, fifo_cnt);
      end else passes++;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (wb_stall !== 1'b0) begin
         $display("FAIL starve_release: got stall=%b, want 0", wb_stall);
      end else passes++;
      tick();
`ifdef WB_ARB_PERF_EN
      checks++;
      if (stall_cycles !== 32'd2) begin
         $display("FAIL perf_stalls: got %0d, want 2", stall_cycles);
      end else passes++;
`endif
      $display("test_starvation done");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_squash();
      int writes_rd10;
      // Older long-latency result to rd10, pipeline busy elsewhere.
      drive(1, 4, 32'h4444, 1, 10, 32'hBEEF);
      tick();
      writes_rd10 = 0;
      // Younger pipeline write to rd10 squashes the buffered entry.
      drive(1, 10, 32'h1111, 0, 0, 0);
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h1111}) begin
         $display("FAIL squash_pipe: got we=%b addr=%0d data=%h, want 1/10/00001111",
                  rf_we, rf_waddr, rf_wdata);
      end else passes++;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if ({rf_we, fifo_cnt} !== {1'b0, CW'(0)}) begin
         $display("FAIL squash_pop: got we=%b cnt=%0d, want 0/0", rf_we, fifo_cnt);
      end else passes++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rf_we === 1'b1 && rf_waddr === 5'd10) writes_rd10++;
      end
      checks++;
      if (writes_rd10 != 0) begin
         $display("FAIL squash_stale: got %0d later rd10 writes, want 0", writes_rd10);
      end else passes++;
      // Push coinciding with a matching pipeline write is not squashed.
      drive(1, 12, 32'hC0C0, 1, 12, 32'hD00D);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'hD00D}) begin
         $display("FAIL squash_samecycle: got we=%b addr=%0d data=%h, want 1/12/0000d00d",
                  rf_we, rf_waddr, rf_wdata);
      end else passes++;
      tick();
      $display("test_squash done");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset_mid();
      drive(1, 3, 32'h5, 1, 14, 32'hE0);
      tick();
      drive(1, 3, 32'h6, 1, 15, 32'hF0);
      tick();
      checks++;
      if (fifo_cnt !== CW'(2)) begin
         $display("FAIL rstmid_fill: got cnt=%0d, want 2", fifo_cnt);
      end else passes++;
      drive(0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, fifo_cnt, ll_ready, wb_stall} !==
          {1'b0, 5'd0, 32'd0, CW'(0), 1'b1, 1'b0}) begin
         $display("FAIL rstmid_clear: got we=%b addr=%0d data=%h cnt=%0d ready=%b stall=%b",
                  rf_we, rf_waddr, rf_wdata, fifo_cnt, ll_ready, wb_stall);
      end else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({rf_we, fifo_cnt} !== {1'b0, CW'(0)}) begin
            $display("FAIL rstmid_after%0d: got we=%b cnt=%0d, want 0/0", i, rf_we, fifo_cnt);
         end else passes++;
      end
`ifdef WB_ARB_PERF_EN
      checks++;
      if (stall_cycles !== 32'd0) begin
         $display("FAIL rstmid_perf: got %0d, want 0", stall_cycles);
      end else passes++;
`endif
      $display("test_reset_mid done");
   endtask

   // -------------------------------------------------------------------------
   task automatic test_random();
      logic        v, lv, exp_stall, exp_ready, e_we, cand, push;
      logic [4:0]  rd, lrd, e_addr;
      logic [31:0] d, ld, e_data;
      int          occ, errs_before;
      ent_t        h, n;

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b1;
      m_q.delete();
      m_force  = 0;
      m_starve = 0;
      m_stalls = 0;
      tick();

      for (int c = 0; c < 600; c++) begin
         v   = ($urandom_range(0, 99) < 70);
         rd  = 5'($urandom_range(0, 7));
         d   = $urandom;
         lv  = ($urandom_range(0, 99) < 45);
         lrd = 5'($urandom_range(0, 7));
         ld  = $urandom;
         drive(v, rd, d, lv, lrd, ld);
         #1;

         exp_stall = m_force;
         exp_ready = (m_q.size() < DEPTH);
         checks++;
         if ({wb_stall, ll_ready} !== {exp_stall, exp_ready}) begin
            $display("FAIL rand_comb c%0d: got stall=%b ready=%b, want %b/%b",
                     c, wb_stall, ll_ready, exp_stall, exp_ready);
         end else passes++;

         // Model: the pipeline wins unless stalled or writing x0; otherwise
         // the oldest buffered result leaves (possibly as a dead write).
         occ    = m_q.size();
         cand   = v && !m_force && (rd != 5'd0);
         push   = lv && exp_ready;
         e_we   = 1'b0;
         e_addr = 5'd0;
         e_data = 32'd0;
         if (m_force) m_stalls++;
         if (cand) begin
            e_we   = 1'b1;
            e_addr = rd;
            e_data = d;
            foreach (m_q[k]) if (m_q[k].rd == rd) m_q[k].v = 1'b0;
         end else if (occ > 0) begin
            h      = m_q.pop_front();
            e_we   = h.v && (h.rd != 5'd0);
            e_addr = h.rd;
            e_data = h.data;
         end
         if (m_force) begin
            m_force  = 0;
            m_starve = 0;
         end else if (cand && occ > 0) begin
            m_starve++;
            if (m_starve == STARVE_LIMIT) begin
               m_force  = 1;
               m_starve = 0;
            end
         end else begin
            m_starve = 0;
         end
         if (push) begin
            n.rd   = lrd;
            n.data = ld;
            n.v    = 1'b1;
            m_q.push_back(n);
         end

         tick();

         errs_before = checks - passes;
         checks++;
         if (rf_we !== e_we) begin
            $display("FAIL rand_we c%0d: got %b, want %b", c, rf_we, e_we);
         end else passes++;
         if (e_we) begin
            checks++;
            if ({rf_waddr, rf_wdata} !== {e_addr, e_data}) begin
               $display("FAIL rand_wr c%0d: got addr=%0d data=%h, want %0d/%h",
                        c, rf_waddr, rf_wdata, e_addr, e_data);
            end else passes++;
         end
         checks++;
         if (fifo_cnt !== CW'(m_q.size())) begin
            $display("FAIL rand_cnt c%0d: got %0d, want %0d", c, fifo_cnt, m_q.size());
         end else passes++;
         checks++;
         if (rf_we === 1'b1 && rf_waddr === 5'd0) begin
            $display("FAIL rand_x0 c%0d: got we=1 addr=0, want no x0 write", c);
         end else passes++;
         // One divergence desynchronizes the model; stop the phase early.
         if ((checks - passes) != errs_before) break;
      end
`ifdef WB_ARB_PERF_EN
      checks++;
      if (stall_cycles !== 32'(m_stalls)) begin
         $display("FAIL rand_perf: got %0d, want %0d", stall_cycles, m_stalls);
      end else passes++;
`endif
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_pipe_write();
      test_ll_drain();
      test_starvation();
      test_squash();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back stage and a long-latency result source (multi-cycle mul/div).
- Long-latency results are buffered in a small FIFO. The pipeline normally has priority.
- A starvation counter forces a one-cycle pipeline stall so the FIFO can drain.
- Squashes buffered stale results when a younger pipeline write targets the same rd, preserving write-after-write (WAW) order.

Parameters:
- DEPTH, 2, long-latency FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive cycles the pipeline may block a non-empty FIFO before a forced drain

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  pipeline WB stage holds a write
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline write-back mux output
- wb_stall  out  1  pipeline must hold WB stage this cycle (combinational)
- ll_valid  in  1  long-latency result offered
- ll_rd  in  5  long-latency destination register
- ll_data  in  32  long-latency result
- ll_ready  out  1  FIFO can accept (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy (registered)

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0, fifo_cnt=0
  - FIFO pointers cleared, all valid bits cleared
  - starve_cnt=0, FSM=ARB_PIPE
  - Reset mid-operation discards all buffered entries.
- Latency: the selected write appears on rf_* the cycle after selection (1-cycle registered).
- Push: ll_ready = (fifo_cnt < DEPTH), independent of same-cycle pop. Push occurs when ll_valid && ll_ready.
- Pipeline write candidate: wb_valid && !wb_stall && wb_rd!=0. Writes with wb_rd==0 produce no rf write and take no port.
- FSM state ARB_PIPE:
  - If a pipeline write candidate exists, it takes the port. In that case the FIFO head is not popped.
  - Otherwise, if the FIFO is non-empty, pop the head; rf_we = head valid && head rd!=0.
  - starve_cnt increments when the FIFO is non-empty and the pipeline takes the port. It clears when the FIFO pops or is empty.
  - When starve_cnt == STARVE_LIMIT-1 and the increment condition holds, go to ARB_FORCE.
- FSM state ARB_FORCE:
  - wb_stall=1 and the head is popped.
  - starve_cnt clears and the FSM returns to ARB_PIPE next cycle.
  - wb_stall is 0 in all other cases.
- WAW squash:
  - When a pipeline write to rd X takes the port, every FIFO entry with rd==X has its valid bit cleared that cycle.
  - Squashed entries still occupy slots. They pop normally with rf_we=0.
  - The port slot of a squashed pop is not reused in the same cycle.
- Simultaneous push and squash:
  - An entry pushed in the same cycle as a matching pipeline write is not squashed.
  - Rationale: the long-latency result is younger by construction, because the issue stage blocks younger instructions on a pending long-latency rd.
- Simultaneous push and pop: both occur. fifo_cnt is unchanged.
- Pointers wrap modulo DEPTH. There is no overflow: pushes only occur when ll_ready=1.
- The x0 rule applies to both sources: rf_we is never 1 with rf_waddr==0.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- When defined, adds output port stall_cycles (32 bits, registered):
  - counts cycles with wb_stall=1
  - saturates at 0xFFFFFFFF
  - reset to 0 asynchronously
- When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, idle inputs → rf_we=0, fifo_cnt=0, ll_ready=1, wb_stall=0 for 10 cycles.
- wb_valid=1, wb_rd=5, wb_data=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. Repeat with wb_rd=0 → rf_we=0.
- Push ll (rd=7, 0xAAAA) with wb_valid=0 → next cycle the entry is popped. rf_we=1, rf_waddr=7, rf_wdata=0xAAAA the following cycle. fifo_cnt returns to 0.
- Fill FIFO (2 pushes, rd=8,9) while wb_valid=1 continuously to rd=3 → ll_ready=0 at fifo_cnt=2. After 4 pipeline writes, wb_stall=1 for exactly one cycle and rd=8 is written. After 4 more pipeline writes, rd=9 is written.
- Push ll rd=10 (0xBEEF), then a pipeline write to rd=10 (0x1111) before drain → final rf writes to rd 10 contain only 0x1111. The squashed pop shows rf_we=0.
- Assert rst_n=0 mid-cycle with fifo_cnt=2 → outputs clear immediately. No buffered write appears after rst_n deasserts. With WB_ARB_PERF_EN, stall_cycles reads 0.
